// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-buffer definitions.
// Entry layout, flag positions and capture FSM encoding.
package uart_rx_fifo_pkg;

  localparam int ENT_W    = 10;
  localparam int ENT_FERR = 9;
  localparam int ENT_PERR = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLEAR    = 2'd1,
    WAIT_LOW = 2'd2
  } cap_state_e;

  function automatic logic [ENT_W-1:0] pack_entry(
    input logic       ferr,
    input logic       perr,
    input logic [7:0] data
  );
    logic [ENT_W-1:0] e;
    e           = '0;
    e[7:0]      = data;
    e[ENT_PERR] = perr;
    e[ENT_FERR] = ferr;
    return e;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_fifo.sv
// Generic first-word-fall-through FIFO with explicit fill count.
// Head entry reads combinationally; empty FIFO presents zero.
module sync_fifo_fwft #(
  parameter int W     = 10,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0] ONE      = 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_wr, do_rd;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);
  assign count = cnt_q;
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + ONE;
      2'b01:   cnt_d = cnt_q - ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; unread slots are never presented.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: drains the engine holding register
// into a FWFT FIFO and tracks overrun stalls.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int WMARK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_rdy,
  input  logic [7:0]       rx_data,
  input  logic             rx_perr,
  input  logic             rx_ferr,
  output logic             rx_clr,
  input  logic             rd,
  output logic [ENT_W-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count,
  output logic             wmark,
  output logic             stall,
  input  logic             stall_clr
);

  localparam logic [AW:0] WM = WMARK[AW:0];

  cap_state_e state_q, state_d;
  logic       rx_clr_q, rx_clr_d;
  logic       rdy_q, blk_q, blk_d;
  logic       stall_q, stall_d;
  logic       cap, stall_set;
  logic       full_w, empty_w;
  logic [AW:0] count_w;

  sync_fifo_fwft #(
    .W     (ENT_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cap),
    .wr_data (pack_entry(rx_ferr, rx_perr, rx_data)),
    .rd_en   (rd),
    .rd_data (rd_data),
    .empty   (empty_w),
    .full    (full_w),
    .count   (count_w)
  );

  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_rdy && !full_w) begin
          cap     = 1'b1;
          state_d = CLEAR;
        end
      end
      CLEAR:    state_d = WAIT_LOW;
      WAIT_LOW: if (!rx_rdy) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    rx_clr_d = (state_d == CLEAR);
  end

  // A blocked byte flags once per episode, plus on any rise while full.
  always_comb begin
    blk_d     = rx_rdy & full_w & (state_q == IDLE);
    stall_set = (rx_rdy & ~rdy_q & full_w) | (blk_d & ~blk_q);
    stall_d   = stall_set | (stall_q & ~stall_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rx_clr_q <= 1'b0;
      rdy_q    <= 1'b0;
      blk_q    <= 1'b0;
      stall_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rx_clr_q <= rx_clr_d;
      rdy_q    <= rx_rdy;
      blk_q    <= blk_d;
      stall_q  <= stall_d;
    end
  end

  assign rx_clr = rx_clr_q;
  assign empty  = empty_w;
  assign full   = full_w;
  assign count  = count_w;
  assign wmark  = (count_w >= WM);
  assign stall  = stall_q;

endmodule
